alu_share_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared 64-bit ALU. It accepts operation requests from two independent clients over valid/ready handshakes and grants the ALU round-robin. It registers operands, drives the combinational ALU for one cycle, and captures result, carry and status flags. It returns the response to the granted client over its own valid/ready channel.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_share_ctrl_if.sv | 44 ++++
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/alu_share_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, status and state definitions for the ALU share controller
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  // Opcode field layout: sel[4:2] selects the operation, sel[1:0] invert the operands
  localparam int INV_A = 0;
  localparam int INV_B = 1;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;

  // Status flag bit indices
  localparam int ST_C = 0;
  localparam int ST_Z = 1;
  localparam int ST_V = 2;
  localparam int ST_N = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [4:0] sel);
    return (sel[4:2] >= OP_OR) && (sel[4:2] <= OP_SHL);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - client request/response channels of the ALU share controller
interface alu_share_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [4:0]       req0_sel;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [4:0]       req1_sel;
  logic             req1_cin;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic [3:0]       rsp_status;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_sel, req1_cin,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_cout, rsp_status, rsp_err,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, req0_cin,
    output req1_valid, req1_a, req1_b, req1_sel, req1_cin,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_cout, rsp_status, rsp_err,
    output rsp0_ready, rsp1_ready
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-input round-robin grant with pointer-update strobe
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served_id,
  output logic       grant_valid,
  output logic       grant_id
);

  logic ptr;

  // The pointer only breaks ties; a lone requester is granted regardless of it
  always_comb begin
    grant_valid = |req;
    grant_id    = (req == 2'b11) ? ptr : req[1];
  end

  // After a served request, favour the other requester next time
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~served_id;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-client arbiter and sequencer for the shared ALU
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic [3:0]       alu_status
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       sel_q;
  logic             cin_q;
  logic             id_q;
  logic             grant_valid, grant_id;
  logic             accept, rsp_hs, rsp_ready_sel;

  rr_arbiter_2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({bus.req1_valid, bus.req0_valid}),
    .update      (rsp_hs),
    .served_id   (id_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign rsp_ready_sel = id_q ? bus.rsp1_ready : bus.rsp0_ready;

  // Next-state and handshake strobes; ready only ever asserted from IDLE
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rsp_hs   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (rsp_ready_sel) begin
          rsp_hs   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept &  grant_id;
  assign bus.rsp0_valid = (state == RESP) & ~id_q;
  assign bus.rsp1_valid = (state == RESP) &  id_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latch the granted request; these registers also drive the ALU pins directly
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
      cin_q <= 1'b0;
      id_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= grant_id ? bus.req1_a   : bus.req0_a;
      b_q   <= grant_id ? bus.req1_b   : bus.req0_b;
      sel_q <= grant_id ? bus.req1_sel : bus.req0_sel;
      cin_q <= grant_id ? bus.req1_cin : bus.req0_cin;
      id_q  <= grant_id;
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;
  assign alu_cin = cin_q;

  // Capture the ALU result at the end of EXEC; illegal opcodes report a fixed error response
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_data   <= '0;
      bus.rsp_cout   <= 1'b0;
      bus.rsp_status <= 4'b0000;
      bus.rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      if (op_legal(sel_q)) begin
        bus.rsp_data   <= alu_out;
        bus.rsp_cout   <= alu_cout;
        bus.rsp_status <= alu_status;
        bus.rsp_err    <= 1'b0;
      end else begin
        bus.rsp_data   <= '0;
        bus.rsp_cout   <= 1'b0;
        bus.rsp_status <= 4'b0010;
        bus.rsp_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [1:0]  req_valid = '0;
  logic [63:0] req_a [2];
  logic [63:0] req_b [2];
  logic [4:0]  req_sel [2];
  logic        req_cin [2];
  logic [1:0]  rsp_ready = '0;
  logic [1:0]  req_ready, rsp_valid;

  logic [63:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_sel;
  logic        alu_cin, alu_cout;
  logic [3:0]  alu_status;

  alu_share_ctrl_if bus ();

  assign bus.req0_valid = req_valid[0];
  assign bus.req1_valid = req_valid[1];
  assign bus.req0_a = req_a[0];
  assign bus.req1_a = req_a[1];
  assign bus.req0_b = req_b[0];
  assign bus.req1_b = req_b[1];
  assign bus.req0_sel = req_sel[0];
  assign bus.req1_sel = req_sel[1];
  assign bus.req0_cin = req_cin[0];
  assign bus.req1_cin = req_cin[1];
  assign bus.rsp0_ready = rsp_ready[0];
  assign bus.rsp1_ready = rsp_ready[1];
  assign req_ready = {bus.req1_ready, bus.req0_ready};
  assign rsp_valid = {bus.rsp1_valid, bus.rsp0_valid};

  alu_share_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_status (alu_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: {result, cout, status}; illegal opcodes yield garbage on purpose
  function automatic logic [68:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] sel, input logic cin);
    logic [63:0] aa, bb, r;
    logic [64:0] s;
    logic c, v;
    aa = sel[0] ? ~a : a;
    bb = sel[1] ? ~b : b;
    c = 1'b0;
    v = 1'b0;
    case (sel[4:2])
      3'd1: r = aa | bb;
      3'd2: r = aa & bb;
      3'd3: r = aa ^ bb;
      3'd4: begin
        s = {1'b0, aa} + {1'b0, bb} + {64'd0, cin};
        r = s[63:0];
        c = s[64];
        v = (aa[63] == bb[63]) && (r[63] != aa[63]);
      end
      3'd5: r = aa >> bb[5:0];
      3'd6: r = aa << bb[5:0];
      default: begin
        r = 64'hDEAD_BEEF_0BAD_F00D;
        c = 1'b1;
      end
    endcase
    return {r, c, r[63], v, (r == 64'd0), c};
  endfunction

  always_comb {alu_out, alu_cout, alu_status} = alu_ref(alu_a, alu_b, alu_sel, alu_cin);

  // Expected client-visible response {data, cout, status, err}
  function automatic logic [69:0] expect_rsp(input logic [63:0] a, input logic [63:0] b,
                                             input logic [4:0] sel, input logic cin);
    if (sel[4:2] == 3'd0 || sel[4:2] == 3'd7) return {64'd0, 1'b0, 4'b0010, 1'b1};
    return {alu_ref(a, b, sel, cin), 1'b0};
  endfunction

  function automatic logic [69:0] observed_rsp();
    return {bus.rsp_data, bus.rsp_cout, bus.rsp_status, bus.rsp_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on client id and consume its response after 'hold' stalled cycles
  task automatic run_one(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] sel, input logic cin, input int hold,
                         output int acc_wait, output int rsp_lat, output logic [69:0] obs,
                         output int unstable);
    int t_acc;
    logic [69:0] first;
    req_a[id] = a;
    req_b[id] = b;
    req_sel[id] = sel;
    req_cin[id] = cin;
    req_valid[id] = 1'b1;
    acc_wait = -1;
    rsp_lat = -1;
    unstable = 0;
    obs = '0;
    t_acc = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[id]) begin
        acc_wait = i;
        t_acc = cyc;
        break;
      end
      step();
    end
    step();
    req_valid[id] = 1'b0;
    if (acc_wait < 0) return;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid[id]) begin
        rsp_lat = cyc - t_acc;
        break;
      end
      step();
    end
    if (rsp_lat < 0) return;
    first = observed_rsp();
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rsp_valid[id] || observed_rsp() !== first) unstable++;
    end
    rsp_ready[id] = 1'b1;
    #1;
    obs = observed_rsp();
    step();
    rsp_ready[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({req_ready, rsp_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_handshake: got %b want 0000", {req_ready, rsp_valid});
    end
    total++;
    if (observed_rsp() !== 70'd0) begin
      bad++;
      $display("FAIL reset_rsp: got %h want 0", observed_rsp());
    end
    total++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== 134'd0) begin
      bad++;
      $display("FAIL reset_alu: got a=%h b=%h sel=%b cin=%b want 0", alu_a, alu_b, alu_sel, alu_cin);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    int aw, rl, un;
    logic [69:0] obs;
    run_one(0, 64'd5, 64'd3, 5'b10000, 1'b0, 0, aw, rl, obs, un);
    total++;
    if (aw !== 0 || rl !== 2) begin
      bad++;
      $display("FAIL add_latency: got wait=%0d lat=%0d want 0/2", aw, rl);
    end
    total++;
    if (obs !== {64'd8, 1'b0, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL add_result: got %h want data 8 cout 0 status 0 err 0", obs);
    end
  endtask

  task automatic test_sub();
    int aw, rl, un;
    logic [69:0] obs;
    run_one(1, 64'd3, 64'd5, 5'b10010, 1'b1, 0, aw, rl, obs, un);
    total++;
    if (rl !== 2) begin
      bad++;
      $display("FAIL sub_latency: got %0d want 2", rl);
    end
    total++;
    if (obs[69:6] !== 64'hFFFF_FFFF_FFFF_FFFE || obs[5] !== 1'b0 || obs[4] !== 1'b1) begin
      bad++;
      $display("FAIL sub_result: got data=%h cout=%b n=%b want FFFFFFFFFFFFFFFE/0/1",
               obs[69:6], obs[5], obs[4]);
    end
  endtask

  task automatic test_illegal();
    int aw, rl, un;
    logic [69:0] obs;
    run_one(0, 64'h1234, 64'h5678, 5'b00000, 1'b1, 1, aw, rl, obs, un);
    total++;
    if (obs !== {64'd0, 1'b0, 4'b0010, 1'b1} || rl !== 2) begin
      bad++;
      $display("FAIL illegal_op: got %h lat=%0d want data 0 status 0010 err 1 lat 2", obs, rl);
    end
  endtask

  task automatic test_alternate();
    int exp_id, prev_c, grants, k;
    int exid[$];
    logic [69:0] exq[$];
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_id = 0;
    prev_c = -1;
    grants = 0;
    rsp_ready = 2'b11;
    for (int c = 0; c < 32; c++) begin
      for (int j = 0; j < 2; j++) begin
        req_a[j] = {$urandom, $urandom};
        req_b[j] = {$urandom, $urandom};
        req_sel[j] = 5'($urandom_range(31, 0));
        req_cin[j] = 1'($urandom_range(1, 0));
      end
      req_valid = (c < 24) ? 2'b11 : 2'b00;
      #1;
      if (rsp_valid != 2'b00) begin
        k = rsp_valid[1] ? 1 : 0;
        total++;
        if (exq.size() == 0 || exid[0] != k || observed_rsp() !== exq[0]) begin
          bad++;
          $display("FAIL alt_response: client %0d got %h want %h", k, observed_rsp(),
                   (exq.size() != 0) ? exq[0] : 70'd0);
        end
        if (exq.size() != 0) begin
          void'(exq.pop_front());
          void'(exid.pop_front());
        end
      end
      if (req_ready != 2'b00) begin
        k = req_ready[1] ? 1 : 0;
        total++;
        if (req_ready == 2'b11 || k != exp_id || (prev_c >= 0 && cyc - prev_c != 3)) begin
          bad++;
          $display("FAIL alt_grant: got ready=%b spacing=%0d want client %0d spacing 3",
                   req_ready, cyc - prev_c, exp_id);
        end
        exq.push_back(expect_rsp(req_a[k], req_b[k], req_sel[k], req_cin[k]));
        exid.push_back(k);
        prev_c = cyc;
        exp_id = 1 - exp_id;
        grants++;
      end
      step();
    end
    rsp_ready = 2'b00;
    total++;
    if (grants < 7 || exq.size() != 0) begin
      bad++;
      $display("FAIL alt_count: got grants=%0d pending=%0d want >=7/0", grants, exq.size());
    end
  endtask

  task automatic test_back_pressure();
    int t;
    logic [69:0] first, exp0, exp1;
    req_a[0] = {$urandom, $urandom};
    req_b[0] = {$urandom, $urandom};
    req_sel[0] = 5'b01100;
    req_cin[0] = 1'b0;
    exp0 = expect_rsp(req_a[0], req_b[0], req_sel[0], req_cin[0]);
    req_valid[0] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[0] && t < 20) begin
      step();
      t++;
    end
    step();
    req_valid[0] = 1'b0;
    req_a[1] = {$urandom, $urandom};
    req_b[1] = {$urandom, $urandom};
    req_sel[1] = 5'b10001;
    req_cin[1] = 1'b1;
    exp1 = expect_rsp(req_a[1], req_b[1], req_sel[1], req_cin[1]);
    req_valid[1] = 1'b1;
    #1;
    total++;
    if (req_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_exec_ready: got req1_ready=%b want 0", req_ready[1]);
    end
    step();
    first = observed_rsp();
    total++;
    if (rsp_valid[0] !== 1'b1 || first !== exp0) begin
      bad++;
      $display("FAIL bp_rsp0: got valid=%b rsp=%h want 1/%h", rsp_valid[0], first, exp0);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid[0] !== 1'b1 || observed_rsp() !== first || req_ready[1] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d got valid=%b rsp=%h req1_ready=%b want 1/%h/0",
                 i, rsp_valid[0], observed_rsp(), req_ready[1], first);
      end
      step();
    end
    rsp_ready[0] = 1'b1;
    #1;
    total++;
    if (req_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_handshake_ready: got req1_ready=%b want 0", req_ready[1]);
    end
    step();
    rsp_ready[0] = 1'b0;
    #1;
    total++;
    if (req_ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL bp_next_accept: got req1_ready=%b want 1", req_ready[1]);
    end
    step();
    req_valid[1] = 1'b0;
    step();
    rsp_ready[1] = 1'b1;
    #1;
    total++;
    if (rsp_valid[1] !== 1'b1 || observed_rsp() !== exp1) begin
      bad++;
      $display("FAIL bp_rsp1: got valid=%b rsp=%h want 1/%h", rsp_valid[1], observed_rsp(), exp1);
    end
    step();
    rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    int aw, rl, un, seen;
    logic [69:0] obs;
    run_one(0, 64'd1, 64'd2, 5'b00100, 1'b0, 0, aw, rl, obs, un);
    req_a[0] = 64'hFFFF;
    req_b[0] = 64'h1;
    req_sel[0] = 5'b10000;
    req_cin[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    for (int i = 0; i < 20 && !req_ready[0]; i++) step();
    step();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid != 2'b00) seen++;
      step();
    end
    total++;
    if (seen != 0 || observed_rsp() !== 70'd0 || alu_a !== 64'd0) begin
      bad++;
      $display("FAIL rst_exec_drop: got rsp_valid cycles=%0d rsp=%h alu_a=%h want 0/0/0",
               seen, observed_rsp(), alu_a);
    end
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rst_exec_pointer: got ready=%b want 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    rsp_ready[0] = 1'b1;
    step();
    step();
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_random();
    int aw, rl, un, id, hold;
    logic [63:0] a, b;
    logic [4:0] sel;
    logic cin;
    logic [69:0] obs, exp;
    for (int n = 0; n < 30; n++) begin
      id = $urandom_range(1, 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sel = 5'($urandom_range(31, 0));
      cin = 1'($urandom_range(1, 0));
      hold = $urandom_range(3, 0);
      exp = expect_rsp(a, b, sel, cin);
      run_one(id, a, b, sel, cin, hold, aw, rl, obs, un);
      total++;
      if (aw !== 0 || rl !== 2 || un !== 0 || obs !== exp) begin
        bad++;
        $display("FAIL random_%0d: client %0d sel=%b wait=%0d lat=%0d unstable=%0d got %h want %h",
                 n, id, sel, aw, rl, un, obs, exp);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 2; j++) begin
      req_a[j] = '0;
      req_b[j] = '0;
      req_sel[j] = '0;
      req_cin[j] = 1'b0;
    end
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_alternate();
    test_back_pressure();
    test_reset_in_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
